// File: rtl/shift_normalizer.sv
// shift_normalizer: iterative 32-bit normalizer.
// Counts leading zeros (unsigned mode) or redundant sign bits (signed mode)
// with a five-step binary search (k = 16, 8, 4, 2, 1). It produces the
// normalized operand Z, the applied left-shift amount S and a
// no-significant-bits flag ZERO. One result is produced every 7 cycles.
module shift_normalizer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] X,
    input  logic        SIGNED,
    output logic        busy,
    output logic        done,
    output logic [31:0] Z,
    output logic [4:0]  S,
    output logic        ZERO
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Index of the last search step (k = 1).
    localparam logic [2:0] LAST_STEP = 3'd4;

    // Decide whether the top k bits of w (k = 16 >> step) carry no
    // information and can be shifted out. In signed mode one extra bit is
    // examined so that a single copy of the sign bit always survives.
    function automatic logic step_take(input logic [31:0] w,
                                       input logic [2:0]  step,
                                       input logic        sgn);
        logic take;
        case (step)
            3'd0: take = sgn ? ((w[31:15] == {17{1'b0}}) || (w[31:15] == {17{1'b1}}))
                             :  (w[31:16] == 16'h0000);
            3'd1: take = sgn ? ((w[31:23] == 9'h000) || (w[31:23] == 9'h1FF))
                             :  (w[31:24] == 8'h00);
            3'd2: take = sgn ? ((w[31:27] == 5'h00) || (w[31:27] == 5'h1F))
                             :  (w[31:28] == 4'h0);
            3'd3: take = sgn ? ((w[31:29] == 3'h0) || (w[31:29] == 3'h7))
                             :  (w[31:30] == 2'h0);
            3'd4: take = sgn ? (w[31] == w[30])
                             : (w[31] == 1'b0);
            default: take = 1'b0;
        endcase
        return take;
    endfunction

    // Operand with no significant bits: all zeros, or all ones in signed mode.
    function automatic logic no_sig_bits(input logic [31:0] x, input logic sgn);
        return (x == 32'h0000_0000) || (sgn && (x == 32'hFFFF_FFFF));
    endfunction

    logic [1:0]  state_r;
    logic [2:0]  step_r;
    logic [31:0] w_r;
    logic [4:0]  acc_r;
    logic        mode_r;
    logic        zero_cap_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] z_r;
    logic [4:0]  s_r;
    logic        zero_r;

    logic [4:0]  k_s;
    logic        take_s;
    logic [31:0] w_next_s;
    logic [4:0]  acc_next_s;

    // One search step: shift W and grow the accumulator when the top bits are redundant.
    always_comb begin
        k_s        = 5'd16 >> step_r;
        take_s     = step_take(w_r, step_r, mode_r);
        w_next_s   = w_r;
        acc_next_s = acc_r;
        if (take_s) begin
            w_next_s   = w_r << k_s;
            acc_next_s = acc_r + k_s;
        end else begin
            w_next_s   = w_r;
            acc_next_s = acc_r;
        end
    end

    // Control FSM, working registers and registered result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            step_r     <= 3'd0;
            w_r        <= 32'h0000_0000;
            acc_r      <= 5'd0;
            mode_r     <= 1'b0;
            zero_cap_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            z_r        <= 32'h0000_0000;
            s_r        <= 5'd0;
            zero_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        w_r        <= X;
                        acc_r      <= 5'd0;
                        mode_r     <= SIGNED;
                        zero_cap_r <= no_sig_bits(X, SIGNED);
                        step_r     <= 3'd0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    w_r   <= w_next_s;
                    acc_r <= acc_next_s;
                    if (step_r == LAST_STEP) begin
                        z_r     <= w_next_s;
                        s_r     <= acc_next_s;
                        zero_r  <= zero_cap_r;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        step_r <= step_r + 3'd1;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign Z    = z_r;
    assign S    = s_r;
    assign ZERO = zero_r;

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed and random bench for shift_normalizer with an independent
// bit-counting reference model.
module tb_shift_normalizer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] X;
    logic        SIGNED;
    logic        busy;
    logic        done;
    logic [31:0] Z;
    logic [4:0]  S;
    logic        ZERO;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    shift_normalizer dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .X      (X),
        .SIGNED (SIGNED),
        .busy   (busy),
        .done   (done),
        .Z      (Z),
        .S      (S),
        .ZERO   (ZERO)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: count leading zeros / leading sign copies bit by bit.
    task automatic model(input logic [31:0] x, input logic sgn,
                         output logic [31:0] ez, output logic [4:0] es, output logic ezero);
        int n;
        n = 0;
        for (int b = 31; b >= 0; b--) begin
            if (x[b] == (sgn ? x[31] : 1'b0)) n++;
            else break;
        end
        if (n == 32) begin
            es    = 5'd31;
            ezero = 1'b1;
        end else begin
            es    = sgn ? 5'(n - 1) : 5'(n);
            ezero = 1'b0;
        end
        ez = x << es;
    endtask

    // One isolated request with full latency / pulse-width checking.
    task automatic run_one(input string tag, input logic [31:0] x, input logic sgn,
                           input logic [31:0] ez, input logic [4:0] es, input logic ezero);
        X = x; SIGNED = sgn; start = 1'b1;
        tick();                          // edge N: accept
        start = 1'b0; X = ~x; SIGNED = ~sgn;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk({tag, "_early_done"}, 32'(done), 32'd0);
        end
        tick();                          // edge N+5
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_Z"}, Z, ez);
        chk({tag, "_S"}, 32'(S), 32'(es));
        chk({tag, "_ZERO"}, 32'(ZERO), 32'(ezero));
        tick();                          // edge N+6
        chk({tag, "_done_low"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_Z_hold"}, Z, ez);
    endtask

    initial begin
        logic [31:0] nx, ez, r;
        logic [4:0]  es;
        logic        ns, ezero;
        int          ndone, acc_cyc, prev_done;
        bit          got;

        reset = 1'b1; start = 1'b1; X = 32'h1234_5678; SIGNED = 1'b0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_Z", Z, 32'd0);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_ZERO", 32'(ZERO), 32'd0);
        reset = 1'b0; start = 1'b0;
        tick();

        run_one("u1",     32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0);
        run_one("s1",     32'h0000_0001, 1'b1, 32'h4000_0000, 5'd30, 1'b0);
        run_one("sfff0",  32'hFFFF_FFF0, 1'b1, 32'h8000_0000, 5'd27, 1'b0);
        run_one("u0",     32'h0000_0000, 1'b0, 32'h0000_0000, 5'd31, 1'b1);
        run_one("sneg1",  32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 5'd31, 1'b1);
        run_one("umsb",   32'h8000_0000, 1'b0, 32'h8000_0000, 5'd0,  1'b0);
        run_one("s0",     32'h0000_0000, 1'b1, 32'h0000_0000, 5'd31, 1'b1);
        run_one("u00f0",  32'h00F0_0000, 1'b0, 32'hF000_0000, 5'd8,  1'b0);

        // start while busy is ignored; operand change mid-flight has no effect
        X = 32'h0001_0000; SIGNED = 1'b0; start = 1'b1;
        tick();                          // N
        start = 1'b0;
        tick();                          // N+1
        start = 1'b1; X = 32'h0000_0003;
        tick();                          // N+2
        start = 1'b0; X = 32'h1234_5678; SIGNED = 1'b1;
        tick(); tick();                  // N+3, N+4
        chk("busy_ign_early", 32'(done), 32'd0);
        tick();                          // N+5
        chk("busy_ign_done", 32'(done), 32'd1);
        chk("busy_ign_Z", Z, 32'h8000_0000);
        chk("busy_ign_S", 32'(S), 32'd15);
        chk("busy_ign_ZERO", 32'(ZERO), 32'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("busy_ign_extra_done", 32'(ndone), 32'd0);
        chk("busy_ign_idle", 32'(busy), 32'd0);

        // reset mid-flight aborts without a done pulse
        X = 32'h0001_0000; SIGNED = 1'b0; start = 1'b1;
        tick();                          // N
        start = 1'b0;
        tick(); tick();                  // N+1, N+2
        reset = 1'b1;
        tick();                          // N+3
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_Z", Z, 32'd0);
        chk("abort_S", 32'(S), 32'd0);
        chk("abort_ZERO", 32'(ZERO), 32'd0);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        run_one("after_rst", 32'h0000_7FFF, 1'b1, 32'h7FFF_0000, 5'd16, 1'b0);

        // random back-to-back requests with start held high throughout
        prev_done = 0;
        start = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            r  = $urandom();
            nx = $urandom() >> r[4:0];
            ns = r[5];
            if (r[7:6] == 2'd3) nx = ~nx;
            if (i % 97 == 0) nx = 32'h0000_0000;
            if (i % 97 == 1) nx = 32'hFFFF_FFFF;
            X = nx; SIGNED = ns;
            model(nx, ns, ez, es, ezero);
            tick();                      // accept
            acc_cyc = cyc;
            r = $urandom(); X = r; SIGNED = r[31];
            got = 1'b0;
            for (int j = 0; j < 8 && !got; j++) begin
                tick();
                if (done) got = 1'b1;
            end
            chk("rnd_latency", 32'(cyc - acc_cyc), 32'd5);
            chk("rnd_Z", Z, ez);
            chk("rnd_S", 32'(S), 32'(es));
            chk("rnd_ZERO", 32'(ZERO), 32'(ezero));
            if (i > 0) chk("rnd_spacing", 32'(cyc - prev_done), 32'd7);
            prev_done = cyc;
            tick();                      // back to IDLE
        end
        start = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_normalizer.md
SHIFT_NORMALIZER -- requirements
Module: shift_normalizer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports in this order:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- X  in  32  operand; captured on the accepted start
- SIGNED  in  1  mode; captured with X (0 = count leading zeros, 1 = count redundant sign bits)
- busy  out  1  high while a request is in flight (SHIFT or DONE)
- done  out  1  one-cycle result-valid pulse
- Z  out  32  normalized operand
- S  out  5  left-shift amount applied to produce Z
- ZERO  out  1  operand had no significant bits: X==0, or SIGNED and X==32'hFFFFFFFF

Function
REQ-002 The block SHALL be an iterative FSM with states IDLE, SHIFT and DONE, and a step counter selecting k = 16, 8, 4, 2, 1.
REQ-003 In IDLE, start=1 at a rising edge SHALL:
- load the working register W with X, the accumulator with 0, and the mode with SIGNED;
- set k=16 and enter SHIFT.
REQ-004 In SHIFT, each edge SHALL apply one step:
- unsigned: if W[31:32-k] is all zero, then W <= W<<k and the accumulator increases by k;
- signed: if W[31:31-k] is all equal, then W <= W<<k and the accumulator increases by k;
- otherwise W and the accumulator hold;
- k then halves.
REQ-005 After the k=1 step the FSM SHALL enter DONE, register Z=W and S=accumulator, and assert done for exactly one cycle.
REQ-006 Latency: if start is accepted at edge N, the steps SHALL occur at edges N+1..N+5, done SHALL be high between edges N+5 and N+6, and the FSM SHALL return to IDLE at edge N+6.
REQ-007 Throughput SHALL be one result per 7 cycles; a new start SHALL be accepted at the first edge in IDLE after done.
REQ-008 start while busy=1 SHALL be ignored: no effect on state, outputs or the captured operand.
REQ-009 Changes on X or SIGNED after capture SHALL NOT affect the result in flight.
REQ-010 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-011 Z, S and ZERO SHALL update only on entry to DONE and hold through IDLE until the next result.
REQ-012 The shift amount SHALL saturate at 31: unsigned X=0 yields Z=0, S=31, ZERO=1; signed X=32'hFFFFFFFF yields Z=32'h80000000, S=31, ZERO=1.
REQ-013 For unsigned mode with X≠0, S SHALL equal the leading-zero count of X and Z SHALL equal X<<S, with Z[31]=1.
REQ-014 For signed mode, when ZERO=0, S SHALL equal the number of leading bits equal to X[31] minus one, Z SHALL equal X<<S, and Z[31]≠Z[30].
REQ-015 ZERO SHALL be computed from the captured operand and mode, and registered with Z and S.
REQ-016 Z and S SHALL match the reference expressions bit-exactly, with no X or Z values on any output after reset.

Reset
REQ-017 reset=1 at a rising edge SHALL force IDLE and set busy=0, done=0, Z=0, S=0, ZERO=0, W=0 and the accumulator to 0, taking priority over start.
REQ-018 reset asserted in SHIFT or DONE SHALL abort the request with no done pulse; the first start after reset deasserts SHALL be accepted normally.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Unsigned X=32'h00000001, start at edge N -> done during N+5..N+6, Z=32'h80000000, S=31, ZERO=0.
- Signed X=32'h00000001 -> Z=32'h40000000, S=30, ZERO=0; signed X=32'hFFFFFFF0 -> Z=32'h80000000, S=27.
- Unsigned X=0 -> Z=0, S=31, ZERO=1; signed X=32'hFFFFFFFF -> Z=32'h80000000, S=31, ZERO=1; unsigned X=32'h80000000 -> Z unchanged, S=0.
- start pulsed with X=32'h00000003 at N+2, while busy on X=32'h00010000 -> only one done, with Z=32'h80000000 and S=15; X changed mid-flight has no effect.
- reset at edge N+3 of a request -> no done pulse, all outputs 0 next cycle; the next start completes correctly.
- 10,000 random X and SIGNED, back-to-back starts -> every result matches the REQ-013/014 model, with done spacing of exactly 7 cycles.
